// File: rtl/freq_sweep_peak.sv
// Frequency-sweep peak tracker: steps freq_out over a window, averages
// folded ADC magnitudes per point, keeps the best. Option: FREQ_SWEEP_FINE_EN.
module freq_sweep_peak #(
  parameter int FREQ_W      = 20,
  parameter int ADC_W       = 12,
  parameter int CNT_W       = 24,
  parameter int STARTUP_CYC = 200000,
  parameter int SETTLE_CYC  = 200000,
  parameter int AVG_LOG2    = 2,
  parameter logic [FREQ_W-1:0] F_DEFAULT = 20'h88B8,
  parameter int FINE_SHIFT  = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      enable,
  input  logic                      start,
  input  logic [FREQ_W-1:0]         f_start,
  input  logic [FREQ_W-1:0]         f_stop,
  input  logic [FREQ_W-1:0]         f_step,
  input  logic [ADC_W-1:0]          adc,
  input  logic                      adc_valid,
  output logic [FREQ_W-1:0]         freq_out,
  output logic [FREQ_W-1:0]         best_freq,
  output logic [ADC_W-2+AVG_LOG2:0] best_mag,
  output logic                      busy,
  output logic                      done
);

  localparam int MAG_W = ADC_W - 1;
  localparam int SUM_W = ADC_W - 1 + AVG_LOG2;
  localparam int NSAMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE, STARTUP, SETTLE, ACCUM, EVAL, DONE
  } state_t;

  state_t state;
  logic startPrev;
  logic [FREQ_W-1:0] startR, stopR, stepR;
  logic [CNT_W-1:0] cnt;
  logic [AVG_LOG2:0] sampCnt;
  logic [SUM_W-1:0] sum;

  logic [MAG_W-1:0] mag;
  logic [SUM_W-1:0] sumNext;
  logic [FREQ_W:0] nf;
  logic better;
  logic [FREQ_W-1:0] newBest;
  logic [FREQ_W-1:0] curStop, curStep;
  logic abort;

  assign mag = adc[ADC_W-1] ? ~adc[ADC_W-2:0] : adc[ADC_W-2:0];
  assign sumNext = sum + SUM_W'(mag);
  assign nf = {1'b0, freq_out} + {1'b0, curStep};
  assign better = sum > best_mag;
  assign newBest = better ? freq_out : best_freq;
  assign abort = (state != IDLE) && (state != DONE)
              && (!enable || !start);

`ifdef FREQ_SWEEP_FINE_EN
  logic fine;
  logic [FREQ_W-1:0] winStop, winStep;
  logic [FREQ_W:0] loSum, hiSum;
  logic [FREQ_W-1:0] lo, hi, stepSh, fineStep;

  assign curStop = fine ? winStop : stopR;
  assign curStep = fine ? winStep : stepR;
  // Fine window is clamped to the coarse window on both sides.
  assign loSum = {1'b0, startR} + {1'b0, stepR};
  assign hiSum = {1'b0, newBest} + {1'b0, stepR};
  assign lo = ({1'b0, newBest} >= loSum) ?
              newBest - stepR : startR;
  assign hi = (hiSum > {1'b0, stopR}) ?
              stopR : hiSum[FREQ_W-1:0];
  assign stepSh = stepR >> FINE_SHIFT;
  assign fineStep = (stepSh == '0) ? FREQ_W'(1) : stepSh;
`else
  assign curStop = stopR;
  assign curStep = stepR;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      startPrev <= 1'b0;
      freq_out  <= F_DEFAULT;
      best_freq <= F_DEFAULT;
      best_mag  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      startR    <= '0;
      stopR     <= '0;
      stepR     <= '0;
      cnt       <= '0;
      sampCnt   <= '0;
      sum       <= '0;
`ifdef FREQ_SWEEP_FINE_EN
      fine      <= 1'b0;
      winStop   <= '0;
      winStep   <= '0;
`endif
    end else begin
      startPrev <= start;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        done     <= 1'b0;
        freq_out <= startR;
      end else begin
        unique case (state)
          IDLE: begin
            if (enable && start && !startPrev) begin
              startR    <= f_start;
              stopR     <= f_stop;
              stepR     <= f_step;
              freq_out  <= f_start;
              best_freq <= f_start;
              best_mag  <= '0;
              busy      <= 1'b1;
              cnt       <= '0;
              state     <= STARTUP;
`ifdef FREQ_SWEEP_FINE_EN
              fine      <= 1'b0;
`endif
            end
          end
          STARTUP: begin
            if (cnt == CNT_W'(STARTUP_CYC - 1)) begin
              cnt     <= '0;
              sum     <= '0;
              sampCnt <= '0;
              state   <= ACCUM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
              cnt     <= '0;
              sum     <= '0;
              sampCnt <= '0;
              state   <= ACCUM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACCUM: begin
            if (adc_valid) begin
              sum <= sumNext;
              if (sampCnt == (AVG_LOG2+1)'(NSAMP - 1))
                state <= EVAL;
              else
                sampCnt <= sampCnt + 1'b1;
            end
          end
          EVAL: begin
            if (better) begin
              best_mag  <= sum;
              best_freq <= freq_out;
            end
            if (nf > {1'b0, curStop}) begin
`ifdef FREQ_SWEEP_FINE_EN
              if (!fine) begin
                fine     <= 1'b1;
                winStop  <= hi;
                winStep  <= fineStep;
                freq_out <= lo;
                cnt      <= '0;
                state    <= SETTLE;
              end else begin
                freq_out <= newBest;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end
`else
              freq_out <= newBest;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
`endif
            end else begin
              freq_out <= nf[FREQ_W-1:0];
              cnt      <= '0;
              state    <= SETTLE;
            end
          end
          DONE: begin
            if (!enable || !start) begin
              done  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_sweep_peak.sv
// Self-checking bench for freq_sweep_peak with a frequency-dependent ADC
// model and a scoreboard of expected sweep points.
module tb_freq_sweep_peak;
  localparam int FW = 20;
  localparam int AW = 12;
  localparam int SC = 10;
  localparam int SE = 4;
  localparam int AL = 1;
  localparam int NA = 2;
  localparam int FSH = 1;
  localparam int MW = AW - 1 + AL;

  logic clk = 1'b0;
  logic nrst, enable, start, adcValid;
  logic [FW-1:0] fStart, fStop, fStep;
  logic [AW-1:0] adc;
  logic [FW-1:0] freqOut, bestFreq;
  logic [MW-1:0] bestMag;
  logic busy, done;

  int total = 0;
  int passed = 0;

  int pkF, altF;
  logic [AW-1:0] pkAdc, altAdc, baseAdc;

  int expQ[$];
  int obsQ[$];
  int expBest, expMag, expCyc;
  int obsCyc;
  logic obsTo, obsBusy1;
  logic [FW-1:0] obsF1;

  freq_sweep_peak #(
    .FREQ_W(FW), .ADC_W(AW), .CNT_W(24),
    .STARTUP_CYC(SC), .SETTLE_CYC(SE),
    .AVG_LOG2(AL), .F_DEFAULT(20'h88B8),
    .FINE_SHIFT(FSH)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable),
    .start(start), .f_start(fStart),
    .f_stop(fStop), .f_step(fStep),
    .adc(adc), .adc_valid(adcValid),
    .freq_out(freqOut), .best_freq(bestFreq),
    .best_mag(bestMag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] adcOf(input int f);
    if (f == pkF) return pkAdc;
    if (f == altF) return altAdc;
    return baseAdc;
  endfunction

  function automatic int magOf(input logic [AW-1:0] a);
    logic [AW-2:0] m;
    m = a[AW-2:0];
    if (a[AW-1]) m = ~m;
    return int'(m);
  endfunction

  always_comb adc = adcOf(int'(freqOut));

  task automatic setModel(input int pf, input logic [AW-1:0] pa,
                          input int af, input logic [AW-1:0] aa);
    pkF = pf; pkAdc = pa; altF = af; altAdc = aa;
    baseAdc = 12'h100;
  endtask

  task automatic sweepModel(input int fs, input int fe, input int st);
    int f, s;
    f = fs;
    while (1) begin
      s = NA * magOf(adcOf(f));
      if (s > expMag) begin expMag = s; expBest = f; end
      expQ.push_back(f);
      if (f + st > fe) break;
      f = f + st;
    end
  endtask

  task automatic modelRun(input int fs, input int fe, input int st);
    expQ.delete();
    expBest = fs;
    expMag = 0;
    sweepModel(fs, fe, st);
`ifdef FREQ_SWEEP_FINE_EN
    begin
      int lo, hi, fst;
      lo = (expBest - st > fs) ? expBest - st : fs;
      hi = (expBest + st < fe) ? expBest + st : fe;
      fst = (st >> FSH) == 0 ? 1 : (st >> FSH);
      sweepModel(lo, hi, fst);
    end
`endif
    expCyc = 1 + SC + NA + 1 + (expQ.size() - 1) * (SE + NA + 1);
  endtask

  task automatic doRun(input int fs, input int fe, input int st);
    int n;
    logic [FW-1:0] last;
    @(negedge clk);
    fStart = FW'(fs); fStop = FW'(fe); fStep = FW'(st);
    start = 1'b1;
    obsQ.delete();
    obsTo = 1'b0; obsCyc = 0; last = 'x; n = 0;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) begin obsBusy1 = busy; obsF1 = freqOut; end
      if (busy && freqOut !== last) begin
        obsQ.push_back(int'(freqOut));
        last = freqOut;
      end
      if (done) begin obsCyc = n; break; end
      if (n > 500) begin obsTo = 1'b1; break; end
    end
  endtask

  task automatic endRun();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0; enable = 1'b1; start = 1'b0; adcValid = 1'b1;
    fStart = '0; fStop = '0; fStep = 20'd1;
    setModel(-1, 12'h0, -1, 12'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    total++; if (freqOut !== 20'h88B8) $display("FAIL reset_freq got %h want 88b8", freqOut); else passed++;
    total++; if (bestFreq !== 20'h88B8) $display("FAIL reset_best got %h want 88b8", bestFreq); else passed++;
    total++; if (bestMag !== '0) $display("FAIL reset_mag got %h want 0", bestMag); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
  endtask

  task automatic test_peak();
    int e, o;
    setModel(1020, 12'h7F0, -1, 12'h0);
    modelRun(1000, 1040, 10);
    doRun(1000, 1040, 10);
    total++; if (obsTo) $display("FAIL peak_timeout got no done want done"); else passed++;
    total++; if (obsBusy1 !== 1'b1 || obsF1 !== 20'd1000) $display("FAIL peak_cyc1 got busy=%b f=%0d want 1 1000", obsBusy1, obsF1); else passed++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.size() > 0 ? obsQ.pop_front() : -1;
      total++; if (o !== e) $display("FAIL peak_point got %0d want %0d", o, e); else passed++;
    end
    total++; if (obsQ.size() != 0) $display("FAIL peak_extra got %0d want 0", obsQ.size()); else passed++;
    total++; if (bestFreq !== 20'd1020) $display("FAIL peak_best got %0d want 1020", bestFreq); else passed++;
    total++; if (bestMag !== MW'(12'hFE0)) $display("FAIL peak_mag got %h want fe0", bestMag); else passed++;
    total++; if (freqOut !== 20'd1020) $display("FAIL peak_fout got %0d want 1020", freqOut); else passed++;
    total++; if (obsCyc !== expCyc) $display("FAIL peak_cycles got %0d want %0d", obsCyc, expCyc); else passed++;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL peak_hold got %b want 1", done); else passed++;
    endRun();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL peak_ack got done=%b busy=%b want 0 0", done, busy); else passed++;
    total++; if (bestFreq !== 20'd1020) $display("FAIL peak_keep got %0d want 1020", bestFreq); else passed++;
  endtask

  task automatic test_fold_tie();
    int e, o;
    setModel(1010, 12'h80F, 1020, 12'h7F0);
    modelRun(1000, 1040, 10);
    doRun(1000, 1040, 10);
    total++; if (obsTo) $display("FAIL tie_timeout got no done want done"); else passed++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.size() > 0 ? obsQ.pop_front() : -1;
      total++; if (o !== e) $display("FAIL tie_point got %0d want %0d", o, e); else passed++;
    end
    total++; if (bestFreq !== 20'd1010) $display("FAIL tie_best got %0d want 1010", bestFreq); else passed++;
    total++; if (bestMag !== MW'(12'hFE0)) $display("FAIL tie_mag got %h want fe0", bestMag); else passed++;
    total++; if (freqOut !== 20'd1010) $display("FAIL tie_fout got %0d want 1010", freqOut); else passed++;
    endRun();
  endtask

  task automatic test_window();
    int cfg[2][3];
    int e, o;
    cfg = '{'{1000, 1035, 10}, '{2000, 1000, 10}};
    setModel(1020, 12'h7F0, -1, 12'h0);
    for (int i = 0; i < 2; i++) begin
      modelRun(cfg[i][0], cfg[i][1], cfg[i][2]);
      doRun(cfg[i][0], cfg[i][1], cfg[i][2]);
      total++; if (obsTo) $display("FAIL win_timeout cfg %0d got no done want done", i); else passed++;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        o = obsQ.size() > 0 ? obsQ.pop_front() : -1;
        total++; if (o !== e) $display("FAIL win_point cfg %0d got %0d want %0d", i, o, e); else passed++;
      end
      total++; if (obsQ.size() != 0) $display("FAIL win_extra cfg %0d got %0d want 0", i, obsQ.size()); else passed++;
      total++; if (int'(bestFreq) !== expBest) $display("FAIL win_best cfg %0d got %0d want %0d", i, bestFreq, expBest); else passed++;
      total++; if (int'(bestMag) !== expMag) $display("FAIL win_mag cfg %0d got %h want %h", i, bestMag, expMag); else passed++;
      total++; if (obsCyc !== expCyc) $display("FAIL win_cycles cfg %0d got %0d want %0d", i, obsCyc, expCyc); else passed++;
      endRun();
    end
`ifndef FREQ_SWEEP_FINE_EN
    total++; if (bestFreq !== 20'd2000) $display("FAIL win_single got %0d want 2000", bestFreq); else passed++;
`endif
  endtask

  task automatic test_abort();
    int n;
    setModel(1020, 12'h7F0, -1, 12'h0);
    @(negedge clk);
    fStart = 20'd1000; fStop = 20'd1040; fStep = 20'd10;
    start = 1'b1;
    n = 0;
    while (!(busy && freqOut == 20'd1030) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 200) $display("FAIL abort_wait got no 1030 want 1030"); else passed++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); else passed++;
    total++; if (freqOut !== 20'd1000) $display("FAIL abort_fout got %0d want 1000", freqOut); else passed++;
    total++; if (bestFreq !== 20'd1020 || bestMag !== MW'(12'hFE0)) $display("FAIL abort_keep got %0d/%h want 1020/fe0", bestFreq, bestMag); else passed++;
  endtask

  task automatic test_enable();
    logic sawBusy;
    setModel(1020, 12'h7F0, -1, 12'h0);
    @(negedge clk);
    fStart = 20'd1500; fStop = 20'd1600; fStep = 20'd20;
    start = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || freqOut !== 20'd1500) $display("FAIL en_abort got busy=%b f=%0d want 0 1500", busy, freqOut); else passed++;
    enable = 1'b1;
    sawBusy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    total++; if (sawBusy !== 1'b0) $display("FAIL en_norestart got busy=1 want 0"); else passed++;
    endRun();
  endtask

  task automatic test_back_to_back();
    int e, o;
    int pk[2];
    pk = '{1030, 1000};
    for (int i = 0; i < 2; i++) begin
      setModel(pk[i], 12'h7F0, -1, 12'h0);
      modelRun(1000, 1040, 10);
      doRun(1000, 1040, 10);
      total++; if (obsTo) $display("FAIL b2b_timeout run %0d got no done want done", i); else passed++;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        o = obsQ.size() > 0 ? obsQ.pop_front() : -1;
        total++; if (o !== e) $display("FAIL b2b_point run %0d got %0d want %0d", i, o, e); else passed++;
      end
      total++; if (int'(bestFreq) !== pk[i]) $display("FAIL b2b_best run %0d got %0d want %0d", i, bestFreq, pk[i]); else passed++;
      total++; if (int'(bestMag) !== expMag) $display("FAIL b2b_mag run %0d got %h want %h", i, bestMag, expMag); else passed++;
      endRun();
    end
  endtask

`ifdef FREQ_SWEEP_FINE_EN
  task automatic test_fine();
    int e, o;
    setModel(1025, 12'h7F0, 1020, 12'h600);
    modelRun(1000, 1040, 10);
    doRun(1000, 1040, 10);
    total++; if (obsTo) $display("FAIL fine_timeout got no done want done"); else passed++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.size() > 0 ? obsQ.pop_front() : -1;
      total++; if (o !== e) $display("FAIL fine_point got %0d want %0d", o, e); else passed++;
    end
    total++; if (bestFreq !== 20'd1025) $display("FAIL fine_best got %0d want 1025", bestFreq); else passed++;
    total++; if (freqOut !== 20'd1025) $display("FAIL fine_fout got %0d want 1025", freqOut); else passed++;
    total++; if (obsCyc !== expCyc) $display("FAIL fine_cycles got %0d want %0d", obsCyc, expCyc); else passed++;
    endRun();
  endtask
`endif

  initial begin
    test_reset();
    test_peak();
    test_fold_tie();
    test_window();
    test_abort();
    test_enable();
    test_back_to_back();
`ifdef FREQ_SWEEP_FINE_EN
    test_fine();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
